// File: rtl/line_window_gen.sv
// line_window_gen: 4 circular line buffers feeding a registered 3x3 window stream (LINE_WINDOW_ZERO_PAD_EN: zero-padded edge columns).
// Latency: first window 2 cycles after the 3*IMG_WIDTH-th pixel, then one window per cycle for the whole line.
// Backpressure: none; a pixel arriving while all 4 buffers are full is dropped and flagged on sticky o_overflow.
module line_window_gen #(
  parameter int IMG_WIDTH = 512,
  parameter int CNT_W     = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr,
  output logic        o_overflow
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] RD_THRESH = CNT_W'(3 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(4 * IMG_WIDTH);
  localparam logic [COL_W-1:0] WRAP_COL  = COL_W'(IMG_WIDTH - 1);
`ifdef LINE_WINDOW_ZERO_PAD_EN
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
`else
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 3);
`endif

  typedef enum logic {IDLE, RD} state_t;

  logic [7:0]       line_mem [4][IMG_WIDTH];
  logic [COL_W-1:0] wr_col;
  logic [1:0]       wr_line;
  logic [COL_W-1:0] rd_col;
  logic [1:0]       rd_line;
  logic [CNT_W-1:0] pix_cnt;
  state_t           state, state_nxt;
  logic             rd_issue, line_done;
  logic             wr_fire, wr_drop;
  logic [71:0]      win_dat;

  assign wr_fire = i_pixel_data_valid && (pix_cnt != FULL_CNT);
  assign wr_drop = i_pixel_data_valid && (pix_cnt == FULL_CNT);

  // Buffer contents survive reset; only the bookkeeping is cleared.
  always_ff @(posedge i_clk) begin
    if (wr_fire) line_mem[wr_line][wr_col] <= i_pixel_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col  <= '0;
      wr_line <= '0;
    end else if (wr_fire) begin
      if (wr_col == WRAP_COL) begin
        wr_col  <= '0;
        wr_line <= wr_line + 2'd1;
      end else begin
        wr_col  <= wr_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt <= '0;
    end else begin
      case ({wr_fire, line_done})
        2'b10:   pix_cnt <= pix_cnt + CNT_W'(1);
        2'b01:   pix_cnt <= pix_cnt - LINE_CNT;
        2'b11:   pix_cnt <= pix_cnt + CNT_W'(1) - LINE_CNT;
        default: pix_cnt <= pix_cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        if (pix_cnt >= RD_THRESH) state_nxt = RD;
      end
      RD: begin
        rd_issue = 1'b1;
        if (rd_col == LAST_COL) begin
          line_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_col parks at 0 outside RD so each line starts from the first window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      rd_col  <= '0;
      rd_line <= '0;
    end else begin
      state  <= state_nxt;
      rd_col <= (rd_issue && !line_done) ? rd_col + COL_W'(1) : '0;
      if (line_done) rd_line <= rd_line + 2'd1;
    end
  end

  always_comb begin
    logic [1:0] src_line;
    win_dat  = '0;
    src_line = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        src_line = rd_line + 2'(r);
`ifdef LINE_WINDOW_ZERO_PAD_EN
        // rd_col is the centre column; the outer columns at the image edges read as zero.
        if (!((c == 0 && rd_col == '0) || (c == 2 && rd_col == LAST_COL)))
          win_dat[(r*3+c)*8 +: 8] = line_mem[src_line][rd_col + COL_W'(c) - COL_W'(1)];
`else
        win_dat[(r*3+c)*8 +: 8] = line_mem[src_line][rd_col + COL_W'(c)];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
      o_overflow         <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_issue;
      o_intr             <= line_done;
      if (rd_issue) o_pixel_data <= win_dat;
      if (wr_drop)  o_overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: queue-based reference model checked every cycle, plus literal window/timing checks.
module tb_line_window_gen;

  localparam int W = 8;
`ifdef LINE_WINDOW_ZERO_PAD_EN
  localparam int WPL = W;
  localparam int PAD = 1;
  localparam logic [71:0] FIRST1  = 72'h212000111000010000;
  localparam logic [71:0] LAST1   = 72'h002726001716000706;
  localparam logic [71:0] SECOND1 = 72'h313000212000111000;
`else
  localparam int WPL = W - 2;
  localparam int PAD = 0;
  localparam logic [71:0] FIRST1  = 72'h222120121110020100;
  localparam logic [71:0] LAST1   = 72'h272625171615070605;
  localparam logic [71:0] SECOND1 = 72'h323130222120121110;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pix = '0;
  logic        pix_vld = 1'b0;
  logic [71:0] win;
  logic        win_vld, intr, ovf;

  line_window_gen #(.IMG_WIDTH(W), .CNT_W(14)) dut (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(pix_vld),
    .o_pixel_data(win), .o_pixel_data_valid(win_vld), .o_intr(intr), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: stored pixels as a flat queue whose front is always the oldest line's column 0.
  logic [7:0]  mq[$];
  int          rd_pos = -1;
  bit          m_live = 1'b0;
  bit          m_vld, m_intr, m_ovf;
  logic [71:0] m_win;

  logic [71:0] wins[$];
  int          win_cyc[$];
  int          intr_cyc[$];
  int          acc_cyc[$];

  task automatic chk_w(string name, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_b(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] px(int r, int c);
    if (c < 0 || c >= W) return 8'h00;
    return mq[r*W + c];
  endfunction

  always @(posedge clk) begin
    bit issuing;
    bit accept;
    cyc++;
    if (rst) begin
      mq.delete();
      rd_pos = -1;
      m_vld  = 1'b0;
      m_intr = 1'b0;
      m_ovf  = 1'b0;
      m_win  = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      issuing = (rd_pos >= 0);
      m_vld   = issuing;
      m_intr  = 1'b0;
      if (issuing) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            m_win[(r*3+c)*8 +: 8] = px(r, rd_pos + c - PAD);
        m_intr = (rd_pos == WPL - 1);
      end
      accept = pix_vld && (mq.size() < 4*W);
      if (pix_vld && !accept) m_ovf = 1'b1;
      if (m_intr) begin
        repeat (W) void'(mq.pop_front());
        rd_pos = -1;
      end else if (issuing) begin
        rd_pos++;
      end else if (mq.size() >= 3*W) begin
        rd_pos = 0;
      end
      if (accept) begin
        mq.push_back(pix);
        acc_cyc.push_back(cyc);
      end
    end
    #1;
    if (m_live) begin
      chk_b("cyc_valid", win_vld, m_vld);
      chk_b("cyc_intr", intr, m_intr);
      chk_b("cyc_overflow", ovf, m_ovf);
      chk_w("cyc_data", win, m_win);
      if (win_vld === 1'b1) begin
        wins.push_back(win);
        win_cyc.push_back(cyc);
      end
      if (intr === 1'b1) intr_cyc.push_back(cyc);
    end
  end

  task automatic clear_cap();
    wins.delete();
    win_cyc.delete();
    intr_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic drive(bit v, logic [7:0] d);
    @(negedge clk);
    pix_vld = v;
    pix     = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic send_rows(int first, int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = first + i;
      drive(1'b1, 8'(16 * (idx / W) + idx % W));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    pix_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
  endtask

  task automatic check_first_line(string tag);
    chk_i({tag, "_nwin"}, wins.size(), WPL);
    chk_i({tag, "_nintr"}, intr_cyc.size(), 1);
    if (wins.size() >= WPL && acc_cyc.size() >= 24 && intr_cyc.size() >= 1) begin
      chk_w({tag, "_first"}, wins[0], FIRST1);
      chk_w({tag, "_last"}, wins[WPL-1], LAST1);
      chk_i({tag, "_latency"}, win_cyc[0] - acc_cyc[23], 2);
      chk_i({tag, "_intr_at"}, intr_cyc[0], win_cyc[WPL-1]);
      chk_i({tag, "_nogap"}, win_cyc[WPL-1] - win_cyc[0], WPL - 1);
    end
  endtask

  initial begin
    int budget;
    int dens[4];
    dens = '{100, 90, 60, 97};

    // One line buffered, read once
    do_reset();
    chk_b("reset_valid", win_vld, 1'b0);
    chk_b("reset_intr", intr, 1'b0);
    chk_b("reset_overflow", ovf, 1'b0);
    chk_w("reset_data", win, 72'h0);
    send_rows(0, 24);
    idle(15);
    check_first_line("s1");

    // Four rows streamed continuously: two lines of windows
    do_reset();
    send_rows(0, 32);
    idle(25);
    chk_i("s2_nwin", wins.size(), 2*WPL);
    chk_i("s2_nintr", intr_cyc.size(), 2);
    if (wins.size() >= 2*WPL) begin
      chk_w("s2_second_first", wins[WPL], SECOND1);
      chk_i("s2_nogap2", win_cyc[2*WPL-1] - win_cyc[WPL], WPL - 1);
    end

    // Reset during the 3rd window, then a fresh stream
    do_reset();
    send_rows(0, 24);
    budget = 0;
    while (wins.size() < 2 && budget < 40) begin
      idle(1);
      budget++;
    end
    chk_i("s4_reached_win2", int'(wins.size() >= 2), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_b("s4_valid_after_rst", win_vld, 1'b0);
    chk_b("s4_intr_after_rst", intr, 1'b0);
    chk_b("s4_ovf_after_rst", ovf, 1'b0);
    clear_cap();
    send_rows(0, 24);
    idle(15);
    check_first_line("s4");

    // 25th pixel lands on the line-complete edge
    do_reset();
    send_rows(0, 24);
    idle(WPL);
    send_rows(24, 1);
    idle(1);
    chk_i("s5_model_cnt", mq.size(), 17);
    if (intr_cyc.size() >= 1 && acc_cyc.size() >= 25)
      chk_i("s5_same_edge", intr_cyc[0], acc_cyc[24]);
    idle(12);
    chk_i("s5_no_early_rd", wins.size(), WPL);
    send_rows(25, 7);
    idle(25);
    chk_i("s5_nwin", wins.size(), 2*WPL);
    if (wins.size() >= 2*WPL) chk_w("s5_second_first", wins[WPL], SECOND1);

    // Randomized traffic at several densities, with a mid-run reset
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      if (ph == 2) do_reset();
      for (int n = 0; n < 800; n++)
        drive($urandom_range(0, 99) < dens[ph], 8'($urandom));
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
